// File: rtl/tb_status_pkg.sv
// Shared definitions for the TB status peripheral:
// register offsets, magic values, terminal states.
package tb_status_pkg;

  localparam logic [4:0] OFF_PRINT  = 5'h00;
  localparam logic [4:0] OFF_STATUS = 5'h04;
  localparam logic [4:0] OFF_EXIT   = 5'h08;
  localparam logic [4:0] OFF_CYCLE  = 5'h0C;
  localparam logic [4:0] OFF_LEVEL  = 5'h10;

  localparam logic [31:0] PASS_MAGIC = 32'd123456789;
  localparam logic [31:0] FAIL_MAGIC = 32'd1;

  typedef enum logic [1:0] {
    RUNNING,
    PASSED,
    FAILED,
    EXITED
  } term_e;

endpackage

// File: rtl/tb_status_if.sv
// OBI-style data bus between the core and the TB status peripheral.
// master drives requests, slave returns grant and response.
interface tb_status_if;
  logic        req_i;
  logic        gnt_o;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/tb_char_fifo.sv
// Synchronous byte FIFO for buffered stdout characters.
// DEPTH must be a power of two; pointers wrap naturally.
module tb_char_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  output logic [7:0]               data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = count_q[AW];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (do_pop) rptr_q <= rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/tb_status_periph.sv
// TB status peripheral: stdout FIFO, pass/fail/exit flags, cycle counter.
// Optional watchdog enabled by defining TB_STATUS_TIMEOUT_EN.
module tb_status_periph
  import tb_status_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h2000_0000,
  parameter int          FIFO_DEPTH     = 8,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  tb_status_if.slave  bus,
  output logic        char_valid_o,
  input  logic        char_ready_i,
  output logic [7:0]  char_data_o,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o,
  output logic        timeout_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          hit;
  logic [4:0]    off;
  logic          acc;
  logic          wr;
  logic          rd;
  logic          print_w;
  logic          status_w;
  logic          exit_w;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] level;
  logic [31:0]   rdata_d;
  logic          tmo_hit;

  term_e       term_q;
  logic [31:0] cycle_q;
  logic [31:0] exit_value_q;
  logic [31:0] rdata_q;
  logic        rvalid_q;
  logic        timeout_q;

  assign hit = (bus.addr_i[31:5] == BASE_ADDR[31:5]);
  assign off = {bus.addr_i[4:2], 2'b00};

  // Stall decision looks only at registered occupancy.
  assign bus.gnt_o = bus.req_i &
    ~(bus.we_i & hit & (off == OFF_PRINT) & fifo_full);

  assign acc      = bus.req_i & bus.gnt_o;
  assign wr       = acc & bus.we_i & hit;
  assign rd       = acc & ~bus.we_i & hit;
  assign print_w  = wr & (off == OFF_PRINT);
  assign status_w = wr & (off == OFF_STATUS);
  assign exit_w   = wr & (off == OFF_EXIT);
  assign push     = print_w & bus.be_i[0];
  assign pop      = char_valid_o & char_ready_i;

  tb_char_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (bus.wdata_i[7:0]),
    .pop_i   (pop),
    .data_o  (char_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (level)
  );

  assign char_valid_o = ~fifo_empty;

  always_comb begin
    rdata_d = '0;
    unique case (1'b1)
      rd & (off == OFF_CYCLE): rdata_d = cycle_q;
      rd & (off == OFF_LEVEL): rdata_d = 32'(level);
      default:                 rdata_d = '0;
    endcase
  end

`ifdef TB_STATUS_TIMEOUT_EN
  assign tmo_hit = (cycle_q == TIMEOUT_CYCLES - 32'd1);
`else
  logic unused_tmo;
  assign tmo_hit    = 1'b0;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  logic unused_bus;
  assign unused_bus = ^{bus.be_i[3:1], bus.addr_i[1:0]};

  // First terminal event wins; later ones are dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      term_q       <= RUNNING;
      cycle_q      <= '0;
      exit_value_q <= '0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      cycle_q  <= cycle_q + 32'd1;
      rvalid_q <= acc;
      rdata_q  <= rdata_d;
      if (term_q == RUNNING) begin
        if (tmo_hit) begin
          term_q    <= FAILED;
          timeout_q <= 1'b1;
        end else if (status_w && bus.wdata_i == PASS_MAGIC) begin
          term_q <= PASSED;
        end else if (status_w && bus.wdata_i == FAIL_MAGIC) begin
          term_q <= FAILED;
        end else if (exit_w) begin
          term_q       <= EXITED;
          exit_value_q <= bus.wdata_i;
        end
      end
    end
  end

  assign bus.rvalid_o   = rvalid_q;
  assign bus.rdata_o    = rdata_q;
  assign tests_passed_o = (term_q == PASSED);
  assign tests_failed_o = (term_q == FAILED);
  assign exit_valid_o   = (term_q == EXITED);
  assign exit_value_o   = exit_value_q;
  assign timeout_o      = timeout_q;
endmodule

// File: tb/tb_tb_status_periph.sv
// Self-checking bench for tb_status_periph (bus/char scoreboards).
// Watchdog section active when TB_STATUS_TIMEOUT_EN is defined.
module tb_tb_status_periph;
  import tb_status_pkg::*;

  localparam logic [31:0] BASE = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        char_ready = 1'b0;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        passed;
  logic        failed;
  logic        exit_valid;
  logic [31:0] exit_value;
  logic        timeout;

  tb_status_if bus_if ();

  tb_status_periph #(
    .BASE_ADDR      (BASE),
    .FIFO_DEPTH     (8),
    .TIMEOUT_CYCLES (32'd100)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .bus            (bus_if),
    .char_valid_o   (char_valid),
    .char_ready_i   (char_ready),
    .char_data_o    (char_data),
    .tests_passed_o (passed),
    .tests_failed_o (failed),
    .exit_valid_o   (exit_valid),
    .exit_value_o   (exit_value),
    .timeout_o      (timeout)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] rq_exp [$];
  bit          rq_chk [$];
  logic [7:0]  cq [$];
  logic [31:0] rd_last = '0;
  logic [31:0] mon_e;
  bit          mon_c;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus_if.rvalid_o) begin
      if (rq_exp.size() == 0) begin
        chk("spurious_rvalid", bus_if.rvalid_o, 0);
      end else begin
        mon_e   = rq_exp.pop_front();
        mon_c   = rq_chk.pop_front();
        rd_last = bus_if.rdata_o;
        if (mon_c) chk("rdata", bus_if.rdata_o, mon_e);
      end
    end
    if (!rst && char_valid && char_ready) begin
      if (cq.size() == 0) chk("spurious_char", char_valid, 0);
      else chk("char_order", char_data, cq.pop_front());
    end
  end

  task automatic bus_op(input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic [31:0] exp, input bit check_rd);
    int n;
    @(posedge clk); #1;
    bus_if.req_i   = 1'b1;
    bus_if.we_i    = we;
    bus_if.addr_i  = addr;
    bus_if.wdata_i = wd;
    bus_if.be_i    = be;
    n = 0;
    @(negedge clk);
    while (!bus_if.gnt_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus_if.gnt_o) begin
      chk("gnt_timeout", bus_if.gnt_o, 1);
      bus_if.req_i = 1'b0;
      return;
    end
    @(posedge clk);
    rq_exp.push_back(we ? 32'h0 : exp);
    rq_chk.push_back(we ? 1'b1 : check_rd);
    if (we && addr[31:5] == BASE[31:5] && addr[4:2] == 3'd0 && be[0])
      cq.push_back(wd[7:0]);
    #1 bus_if.req_i = 1'b0;
    @(negedge clk);
    chk("rvalid_latency", bus_if.rvalid_o, 1);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wd,
                    input logic [3:0] be);
    bus_op(1'b1, addr, wd, be, 32'h0, 1'b1);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp,
                    input bit check_rd);
    bus_op(1'b0, addr, 32'h0, 4'hF, exp, check_rd);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus_if.req_i = 1'b0;
    rq_exp.delete();
    rq_chk.delete();
    cq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    char_ready = 1'b1;
    n = 0;
    while (cq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", cq.size(), 0);
  endtask

  initial begin
    logic [31:0] c1;
    int n;
    bus_if.req_i   = 1'b0;
    bus_if.we_i    = 1'b0;
    bus_if.addr_i  = '0;
    bus_if.wdata_i = '0;
    bus_if.be_i    = '0;
    do_reset();
    @(negedge clk);
    chk("rst_gnt", bus_if.gnt_o, 0);
    chk("rst_rvalid", bus_if.rvalid_o, 0);
    chk("rst_char_valid", char_valid, 0);
    chk("rst_flags", {passed, failed, exit_valid, timeout}, 0);
    chk("rst_exit_value", exit_value, 0);

`ifdef TB_STATUS_TIMEOUT_EN
    do_reset();
    n = 0;
    forever begin
      @(negedge clk);
      if (timeout || n >= 300) break;
      @(posedge clk);
      n++;
    end
    chk("tmo_cycle", n, 100);
    chk("tmo_flags", {timeout, failed}, 2'b11);
    wr(BASE + 32'h04, PASS_MAGIC, 4'hF);
    chk("tmo_lock_pass", passed, 0);
    do_reset();
    @(negedge clk);
    chk("tmo_rst_clear", {timeout, failed}, 0);
`endif

    char_ready = 1'b1;
    wr(BASE + 32'h00, 32'h41, 4'hF);
    wr(BASE + 32'h00, 32'h42, 4'hF);
    drain();
    rd(BASE + 32'h10, 32'd0, 1'b1);

    char_ready = 1'b0;
    wr(BASE + 32'h00, 32'h55, 4'hE);
    rd(BASE + 32'h10, 32'd0, 1'b1);
    chk("be0_no_push", char_valid, 0);

    for (int i = 0; i < 8; i++) wr(BASE, 32'h60 + i, 4'hF);
    rd(BASE + 32'h10, 32'd8, 1'b1);
    @(posedge clk); #1;
    bus_if.req_i   = 1'b1;
    bus_if.we_i    = 1'b1;
    bus_if.addr_i  = BASE;
    bus_if.wdata_i = 32'h68;
    bus_if.be_i    = 4'hF;
    @(negedge clk);
    chk("stall_full", bus_if.gnt_o, 0);
    @(posedge clk); #1;
    char_ready = 1'b1;
    @(negedge clk);
    chk("stall_same_cycle_pop", bus_if.gnt_o, 0);
    @(posedge clk); #1;
    char_ready = 1'b0;
    @(negedge clk);
    chk("unstall", bus_if.gnt_o, 1);
    @(posedge clk);
    rq_exp.push_back(32'h0);
    rq_chk.push_back(1'b1);
    cq.push_back(8'h68);
    #1 bus_if.req_i = 1'b0;
    @(negedge clk);
    chk("stall_rvalid", bus_if.rvalid_o, 1);
    drain();
    rd(BASE + 32'h10, 32'd0, 1'b1);

    rd(BASE + 32'h0C, 32'h0, 1'b0);
    #1 c1 = rd_last;
    repeat (8) @(posedge clk);
    rd(BASE + 32'h0C, 32'h0, 1'b0);
    #1 chk("cycle_delta", rd_last - c1, 32'd10);
    rd(BASE + 32'h14, 32'h0, 1'b1);
    rd(32'h3000_000C, 32'h0, 1'b1);
    wr(32'h3000_0000, 32'h99, 4'hF);
    chk("miss_no_push", char_valid, 0);

    do_reset();
    char_ready = 1'b0;
    wr(BASE, 32'h77, 4'hF);
    chk("pre_rst_char", char_valid, 1);
    @(posedge clk); #1;
    bus_if.req_i  = 1'b1;
    bus_if.we_i   = 1'b0;
    bus_if.addr_i = BASE + 32'h0C;
    @(posedge clk); #1;
    rst = 1'b1;
    bus_if.req_i = 1'b0;
    rq_exp.delete();
    rq_chk.delete();
    cq.delete();
    @(negedge clk);
    chk("rst_drop_rvalid", bus_if.rvalid_o, 0);
    chk("rst_drop_fifo", char_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    rd(BASE + 32'h10, 32'd0, 1'b1);

    wr(BASE + 32'h08, 32'h5, 4'h1);
    chk("exit_valid", exit_valid, 1);
    chk("exit_value", exit_value, 32'h5);
    wr(BASE + 32'h08, 32'h0, 4'hF);
    chk("exit_locked", exit_value, 32'h5);
    wr(BASE + 32'h04, PASS_MAGIC, 4'hF);
    chk("exit_lock_pass", passed, 0);

    do_reset();
    wr(BASE + 32'h04, 32'd42, 4'hF);
    chk("status_other", {passed, failed}, 0);
    wr(BASE + 32'h04, PASS_MAGIC, 4'hF);
    chk("passed", passed, 1);
    wr(BASE + 32'h04, FAIL_MAGIC, 4'hF);
    chk("pass_lock_fail", failed, 0);
    wr(BASE + 32'h08, 32'h7, 4'hF);
    chk("pass_lock_exit", exit_valid, 0);

    do_reset();
    wr(BASE + 32'h04, FAIL_MAGIC, 4'hF);
    chk("failed", {failed, passed}, 2'b10);

`ifndef TB_STATUS_TIMEOUT_EN
    chk("timeout_off", timeout, 0);
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
